// File: rtl/matmul_mem_pkg.sv
// Shared widths and lane-slice helpers for the four-bank matrix memory.
// Every flat bus packs lane i at bits [W*i +: W].
package matmul_mem_pkg;

  localparam int ADDR_W           = 8;
  localparam int DATA_W           = 16;
  localparam int LANES            = 4;
  localparam int LANE_W           = 2;
  localparam int MEM_LATENCY_DFLT = 2;

  function automatic logic [ADDR_W-1:0] lane_addr(input logic [LANES*ADDR_W-1:0] bus,
                                                  input int lane);
    return bus[lane*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] lane_data(input logic [LANES*DATA_W-1:0] bus,
                                                  input int lane);
    return bus[lane*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker.
// Returns a one-hot winner: the first requester found scanning from ptr_i upward, wrapping.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] win_o
);

  logic [3:0] rot, pick;

  // Rotate so ptr_i sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rot   = 4'(({req_i, req_i} >> ptr_i));
    pick  = rot & (~rot + 4'd1);
    win_o = 4'((({pick, pick} << ptr_i) >> 4));
  end

endmodule

// File: rtl/bank_access_arbiter.sv
// Shares the single address bus of the four-bank memory among four lane requesters.
// Grants all lanes that match the round-robin winner's address, and returns reads with fixed latency.
module bank_access_arbiter
  import matmul_mem_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DFLT
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [LANES-1:0]         req,
  input  logic [LANES-1:0]         we,
  input  logic [LANES*ADDR_W-1:0]  addr,
  input  logic [LANES*DATA_W-1:0]  wdata,
  output logic [LANES-1:0]         gnt,
  output logic [LANES-1:0]         rvalid,
  output logic [LANES*DATA_W-1:0]  rdata,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [LANES-1:0]         mem_write_en,
  output logic [LANES*DATA_W-1:0]  mem_data,
  input  logic [LANES*DATA_W-1:0]  mem_q
);

  logic [LANES-1:0][ADDR_W-1:0] lane_a;
  logic [LANES-1:0][DATA_W-1:0] lane_wd, lane_q;

  for (genvar i = 0; i < LANES; i++) begin : g_unpack
    assign lane_a[i]  = lane_addr(addr, i);
    assign lane_wd[i] = lane_data(wdata, i);
    assign lane_q[i]  = lane_data(mem_q, i);
  end

  logic [LANE_W-1:0]            rr_q, rr_d;
  logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
  logic [LANES-1:0]             mem_we_q;
  logic [LANES-1:0][DATA_W-1:0] mem_data_q;
  logic [LANES-1:0][DATA_W-1:0] rdata_q;
  logic [LANES-1:0]             rvalid_q;
  logic [MEM_LATENCY:0][LANES-1:0] vld_pipe_q;

  logic [LANES-1:0]  win_oh, gnt_w, rd_acc, wr_acc;
  logic [LANE_W-1:0] win_idx;
  logic [ADDR_W-1:0] win_addr;

  rr_pick4 u_pick (
    .req_i (req),
    .ptr_i (rr_q),
    .win_o (win_oh)
  );

  // Grants are gated by reset_n directly so nothing is granted while reset is held.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < LANES; i++)
      if (win_oh[i]) win_idx = LANE_W'(i);
    win_addr = lane_a[win_idx];
    gnt_w    = '0;
    for (int i = 0; i < LANES; i++)
      gnt_w[i] = reset_n & req[i] & (lane_a[i] == win_addr);
    rd_acc     = gnt_w & ~we;
    wr_acc     = gnt_w & we;
    rr_d       = (|gnt_w) ? win_idx + LANE_W'(1) : rr_q;
    mem_addr_d = (|gnt_w) ? win_addr : mem_addr_q;
  end

  // vld_pipe_q[MEM_LATENCY] marks the edge where mem_q holds the lane's read data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_q       <= '0;
      mem_addr_q <= '0;
      mem_we_q   <= '0;
      mem_data_q <= '0;
      vld_pipe_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      rr_q          <= rr_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= wr_acc;
      vld_pipe_q[0] <= rd_acc;
      for (int s = 1; s <= MEM_LATENCY; s++)
        vld_pipe_q[s] <= vld_pipe_q[s-1];
      rvalid_q <= vld_pipe_q[MEM_LATENCY];
      for (int i = 0; i < LANES; i++) begin
        if (wr_acc[i])                  mem_data_q[i] <= lane_wd[i];
        if (vld_pipe_q[MEM_LATENCY][i]) rdata_q[i]    <= lane_q[i];
      end
    end
  end

  assign gnt          = gnt_w;
  assign mem_address  = mem_addr_q;
  assign mem_write_en = mem_we_q;
  assign mem_data     = mem_data_q;
  assign rdata        = rdata_q;
  assign rvalid       = rvalid_q;

endmodule

// File: tb/tb_bank_access_arbiter.sv
// Directed bench for bank_access_arbiter with a two-stage-read, write-first bank model.
module tb_bank_access_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req, we, gnt, rvalid, mem_write_en;
  logic [31:0] addr;
  logic [63:0] wdata, rdata, mem_data;
  logic [7:0]  mem_address;
  logic [3:0][15:0] s1, mq;

  logic [15:0] bank  [4][256];
  bit          wrote [4][256];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bank_access_arbiter dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .mem_address  (mem_address),
    .mem_write_en (mem_write_en),
    .mem_data     (mem_data),
    .mem_q        (mq)
  );

  function automatic logic [15:0] init_val(input int i, input logic [7:0] a);
    if (i == 0 && a == 8'h04) return 16'h0001;
    return {4'(i), 4'h0, a};
  endfunction

  // Memory: address presented after edge E, q valid after edge E+2.
  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_write_en[i]) begin
        bank[i][mem_address]  <= mem_data[16*i +: 16];
        wrote[i][mem_address] <= 1'b1;
      end
      s1[i] <= wrote[i][mem_address] ? bank[i][mem_address] : init_val(i, mem_address);
    end
    mq <= s1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; we = '0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; req = 4'b1111; we = '0; addr = '0; wdata = '0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (mem_address !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", mem_address); end
    checks++; if (mem_write_en !== 4'b0000) begin failures++; $display("FAIL reset_we got=%b exp=0000", mem_write_en); end
    checks++; if (mem_data !== 64'h0) begin failures++; $display("FAIL reset_mdata got=%h exp=0", mem_data); end
    checks++; if (rvalid !== 4'b0000 || rdata !== 64'h0) begin failures++; $display("FAIL reset_rd rvalid=%b rdata=%h exp=0", rvalid, rdata); end
    req = '0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    req = 4'b0001; we = '0; addr[7:0] = 8'h04;
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
    tick();
    req = '0;
    checks++; if (mem_address !== 8'h04 || mem_write_en !== 4'b0000) begin failures++; $display("FAIL single_mem addr=%h we=%b exp=04/0000", mem_address, mem_write_en); end
    checks++; if (rvalid !== 4'b0000) begin failures++; $display("FAIL single_early1 rvalid=%b exp=0000", rvalid); end
    tick();
    tick();
    checks++; if (rvalid !== 4'b0000) begin failures++; $display("FAIL single_early2 rvalid=%b exp=0000", rvalid); end
    tick();
    checks++; if (rvalid !== 4'b0001 || rdata[15:0] !== 16'h0001) begin failures++; $display("FAIL single_ret rvalid=%b rdata0=%h exp=0001/0001", rvalid, rdata[15:0]); end
    tick();
    checks++; if (rvalid !== 4'b0000) begin failures++; $display("FAIL single_pulse rvalid=%b exp=0000", rvalid); end
  endtask

  task automatic test_shared();
    req = 4'b1111; we = 4'b1110; addr = {4{8'h04}};
    wdata = {16'd4, 16'd3, 16'd2, 16'd0};
    #1;
    checks++; if (gnt !== 4'b1111) begin failures++; $display("FAIL shared_gnt got=%b exp=1111", gnt); end
    tick();
    req = '0; we = '0;
    checks++; if (mem_write_en !== 4'b1110 || mem_address !== 8'h04) begin failures++; $display("FAIL shared_we we=%b addr=%h exp=1110/04", mem_write_en, mem_address); end
    checks++; if (mem_data[63:16] !== {16'd4, 16'd3, 16'd2}) begin failures++; $display("FAIL shared_data got=%h exp=000400030002", mem_data[63:16]); end
    tick();
    checks++; if (mem_write_en !== 4'b0000) begin failures++; $display("FAIL shared_wepulse got=%b exp=0000", mem_write_en); end
    tick(); tick();
    checks++; if (rvalid !== 4'b0001 || rdata[15:0] !== 16'h0001) begin failures++; $display("FAIL shared_ret rvalid=%b rdata0=%h exp=0001/0001", rvalid, rdata[15:0]); end
    tick();
  endtask

  task automatic test_raw();
    req = 4'b0100; we = 4'b0100; addr[23:16] = 8'h33; wdata[47:32] = 16'hBEEF;
    #1;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL raw_wgnt got=%b exp=0100", gnt); end
    tick();
    we = '0;
    #1;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL raw_rgnt got=%b exp=0100", gnt); end
    tick();
    req = '0;
    tick(); tick(); tick();
    checks++; if (rvalid !== 4'b0100 || rdata[47:32] !== 16'hBEEF) begin failures++; $display("FAIL raw_ret rvalid=%b rdata2=%h exp=0100/beef", rvalid, rdata[47:32]); end
    tick();
  endtask

  task automatic test_conflict();
    do_reset();
    req = 4'b1111; we = '0; addr = {8'h40, 8'h30, 8'h20, 8'h10};
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (gnt !== 4'(1 << k)) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, gnt, 4'(1 << k)); end
      tick();
      checks++; if (mem_address !== 8'((k + 1) * 16)) begin failures++; $display("FAIL rr_addr%0d got=%h exp=%h", k, mem_address, 8'((k + 1) * 16)); end
      req[k] = 1'b0;
    end
    checks++; if (rvalid !== 4'b0001 || rdata[15:0] !== 16'h0010) begin failures++; $display("FAIL rr_ret0 rvalid=%b rdata0=%h exp=0001/0010", rvalid, rdata[15:0]); end
    req = 4'b1001; addr[7:0] = 8'h50; addr[31:24] = 8'h60;
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rr_wrap got=%b exp=0001", gnt); end
    tick();
    checks++; if (rvalid !== 4'b0010 || rdata[31:16] !== 16'h1020) begin failures++; $display("FAIL rr_ret1 rvalid=%b rdata1=%h exp=0010/1020", rvalid, rdata[31:16]); end
    req[0] = 1'b0;
    #1;
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL rr_wrap3 got=%b exp=1000", gnt); end
    tick();
    req = '0;
    checks++; if (rvalid !== 4'b0100 || rdata[47:32] !== 16'h2030) begin failures++; $display("FAIL rr_ret2 rvalid=%b rdata2=%h exp=0100/2030", rvalid, rdata[47:32]); end
    tick();
    checks++; if (rvalid !== 4'b1000 || rdata[63:48] !== 16'h3040) begin failures++; $display("FAIL rr_ret3 rvalid=%b rdata3=%h exp=1000/3040", rvalid, rdata[63:48]); end
    tick();
    checks++; if (rvalid !== 4'b0001 || rdata[15:0] !== 16'h0050) begin failures++; $display("FAIL rr_ret4 rvalid=%b rdata0=%h exp=0001/0050", rvalid, rdata[15:0]); end
    tick();
    checks++; if (rvalid !== 4'b1000 || rdata[63:48] !== 16'h3060) begin failures++; $display("FAIL rr_ret5 rvalid=%b rdata3=%h exp=1000/3060", rvalid, rdata[63:48]); end
  endtask

  task automatic test_fairness();
    do_reset();
    req = 4'b0101; we = '0; addr[7:0] = 8'h01; addr[23:16] = 8'h02;
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if (gnt !== ((c % 2 == 0) ? 4'b0001 : 4'b0100)) begin
        failures++; $display("FAIL fair_c%0d got=%b exp=%b", c, gnt, (c % 2 == 0) ? 4'b0001 : 4'b0100);
      end
      tick();
    end
    req = '0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_idle();
    req = 4'b0010; we = 4'b0010; addr[15:8] = 8'h5A; wdata[31:16] = 16'h1234;
    tick();
    req = '0; we = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || mem_write_en !== 4'b0000 || mem_address !== 8'h5A || rvalid !== 4'b0000) begin
        failures++; $display("FAIL idle_c%0d gnt=%b we=%b addr=%h rvalid=%b exp=0000/0000/5a/0000", c, gnt, mem_write_en, mem_address, rvalid);
      end
    end
  endtask

  task automatic test_reset_mid();
    req = 4'b1010; we = '0; addr[15:8] = 8'h80; addr[31:24] = 8'h80;
    #1;
    checks++; if (gnt !== 4'b1010) begin failures++; $display("FAIL rmid_gnt got=%b exp=1010", gnt); end
    tick();
    req = '0;
    tick();
    #1 reset_n = 1'b0;
    req = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rmid_gnt0 got=%b exp=0000", gnt); end
    checks++; if (mem_address !== 8'h00 || mem_write_en !== 4'b0000 || mem_data !== 64'h0) begin failures++; $display("FAIL rmid_mem addr=%h we=%b data=%h exp=0", mem_address, mem_write_en, mem_data); end
    checks++; if (rvalid !== 4'b0000 || rdata !== 64'h0) begin failures++; $display("FAIL rmid_rd rvalid=%b rdata=%h exp=0", rvalid, rdata); end
    tick(); tick();
    reset_n = 1'b1; req = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (rvalid !== 4'b0000) begin failures++; $display("FAIL rmid_drop%0d rvalid=%b exp=0000", c, rvalid); end
    end
    req = 4'b0011; addr[7:0] = 8'h01; addr[15:8] = 8'h02;
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rmid_ptr got=%b exp=0001", gnt); end
    req = '0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_shared();
    test_raw();
    test_conflict();
    test_fairness();
    test_idle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bank_access_arbiter.md
Name: bank_access_arbiter

Overview:
- Shares the single address bus of the four-bank matrix memory (`Memory_handle`: one 8-bit address, four 16-bit data/q lanes, four write enables) between four lane requesters, typically the four MAC lanes of the matrix-multiply engine.
- Each lane owns bank i for data and q. Only the address is contended.
- Each cycle the block picks one winning address round-robin and grants every lane requesting that same address.
- It drives the memory with registered outputs and returns read data with fixed latency.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 16, data width per lane.
- LANES, 4, number of requesters/banks (fixed at 4 for this design).
- MEM_LATENCY, 2, clock edges from mem_address presented until mem_q is valid.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  4  lane i requests an access; held until granted.
- we  in  4  lane i request is a write (1) or read (0).
- addr  in  32  lane i address in bits [8i+7:8i].
- wdata  in  64  lane i write data in bits [16i+15:16i].
- gnt  out  4  combinational; a transfer occurs on an edge where req[i]&gnt[i].
- rvalid  out  4  one-cycle pulse; rdata lane valid.
- rdata  out  64  registered read data per lane.
- mem_address  out  8  to memory address.
- mem_write_en  out  4  to memory write enables; active-high, decided for this design.
- mem_data  out  64  to memory data1..data4, lane-sliced.
- mem_q  in  64  from memory q1..q4, lane-sliced.

Behaviour:
- **Reset (async, reset_n=0):**
  - rr_ptr=0; mem_address=0; mem_write_en=0; mem_data=0.
  - rvalid=0; rdata=0; read pipeline valids cleared.
  - gnt=0 while reset_n=0.
- **Winner selection (combinational):**
  - Scan lanes rr_ptr, rr_ptr+1, …, modulo 4; the first lane with req=1 is the winner W.
  - gnt[i]=req[i] & (addr[i]==addr[W]), so all same-address requesters are granted together, reads and writes mixed.
  - No req → gnt=0.
- **Pointer update:** rr_ptr<=W+1 mod 4 on any edge with a grant; it wraps 3→0. Otherwise rr_ptr holds.
- **Memory drive (registered):**
  - On a grant edge: mem_address<=addr[W].
  - mem_write_en[i]<=gnt[i]&we[i].
  - mem_data lane i<=wdata[i] when gnt[i]&we[i], else hold.
  - Edge without grant: mem_write_en<=0, mem_address holds.
  - mem_write_en is a one-cycle pulse per accepted write.
- **Read return:**
  - Read accepted at edge N (gnt[i]&~we[i]): the lane-i valid enters a shift pipeline of depth MEM_LATENCY+1.
  - At edge N+MEM_LATENCY+1: rdata lane i<=mem_q lane i, and rvalid[i]=1 for exactly one cycle.
  - Default: rvalid 3 cycles after the grant edge.
  - Fully pipelined; back-to-back reads each return in order.
  - Writes never raise rvalid.
- **Hazards:**
  - Banks are lane-private, so a same-cycle read and write by different lanes never conflict.
  - A read of an address written by the same lane on a previous edge returns the new data, given memory write-first timing across edges.
- **Reset mid-operation:** in-flight reads are dropped, with no rvalid after reset release. Requesters must reissue.
- **Starvation bound:** a held request is granted within 4 grant cycles.
- **Requester rule:** req/addr/we/wdata are stable while req=1 and gnt=0. Changing them before the grant is a requester error and undefined.

Decomposition:
- **Shared package** `matmul_mem_pkg`:
  - ADDR_W, DATA_W, LANES.
  - MEM_LATENCY default.
  - Lane-slice helper functions for the flat buses.
- **Sub-module** `rr_pick4`: combinational 4-way round-robin picker, inputs req and ptr, outputs a one-hot winner.
- The read-return shift pipeline stays inline.

Test Plan:
- **Single read:** req=0001, we=0, addr0=0x04 → gnt=0001 same cycle; mem_address=0x04, mem_write_en=0000 next cycle. With model q1=0x0001, rvalid=0001 and rdata lane0=0x0001 exactly 3 cycles after the grant edge.
- **Shared address:** all lanes req, addr=0x04, we=1110, wdata=2,3,4 → gnt=1111 in one cycle; mem_write_en=1110 one cycle; lane0 rvalid 3 cycles later.
- **Conflict round-robin:** lanes 0–3 req with addresses 0x10,0x20,0x30,0x40, rr_ptr=0 → grant order lanes 0,1,2,3 on consecutive edges; then rr_ptr wraps to 0; mem_address sequence 0x10,0x20,0x30,0x40.
- **Fairness:** lane0 req constant (re-requests immediately), lane2 req held at a different address → lane2 granted no later than the 2nd grant edge and never starved over 20 cycles.
- **Reset mid-flight:** issue reads on lanes 1,3 (addr 0x80), assert reset_n=0 one cycle later for 2 cycles → all outputs 0 asynchronously; no rvalid after release; rr_ptr=0.
- **Idle:** req=0000 for 5 cycles → gnt=0000, mem_write_en=0000, mem_address unchanged, rvalid=0000.
